// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state type and coordinate type for VGA sync tracking.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // Default 640x480 @ 60 Hz raster
    localparam int unsigned H_TOTAL_DEF      = 800;
    localparam int unsigned V_TOTAL_DEF      = 525;
    localparam int unsigned H_ACTIVE_DEF     = 640;
    localparam int unsigned V_ACTIVE_DEF     = 480;
    localparam int unsigned H_SYNC_START_DEF = 656;
    localparam int unsigned V_SYNC_START_DEF = 490;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_t;

    typedef logic [9:0] coord_t;

    localparam coord_t CNT_MAX = 10'd1023;

    // Measurement counters stick at full scale instead of wrapping
    function automatic coord_t sat_inc(input coord_t v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_fall_det.sv
// Falling-edge detector on an enabled sample stream; holds the previous sample, resets to 1.
// Latency: fall is combinational from the current sample against the stored one.
// Backpressure: none; en qualifies samples, the stored value holds while en is low.
module vga_fall_det (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_in,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    // Capture a new sample only when the strobe is present
    always_comb begin
        prev_d = prev_q;
        if (en) begin
            prev_d = d_in;
        end
    end

    // Previous-sample register, idle-high so a low input right after reset reads as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fall = en & prev_q & ~d_in;

endmodule

// File: rtl/vga_sync_tracker.sv
// Recovers pixel coordinates from hs/vs/blank, measures line/frame length, and locks on good frames.
// Latency: every output is registered, 1 Clk after the pix_en sample it reflects.
// Backpressure: none; pix_en is a free-running strobe and the tracker never stalls the source.
module vga_sync_tracker
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pix_en,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_in,
    output logic [9:0] RecX,
    output logic [9:0] RecY,
    output logic       active,
    output logic       locked,
    output logic       new_frame,
    output logic       line_err,
    output logic       frame_err,
    output logic       blank_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    localparam coord_t     HT      = coord_t'(H_TOTAL);
    localparam coord_t     HT_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t     VT      = coord_t'(V_TOTAL);
    localparam coord_t     VT_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t     HA      = coord_t'(H_ACTIVE);
    localparam coord_t     VA      = coord_t'(V_ACTIVE);
    localparam coord_t     HSS     = coord_t'(H_SYNC_START);
    localparam coord_t     VSS     = coord_t'(V_SYNC_START);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    logic hs_fall;
    logic vs_fall;
    logic do_reload;

    sync_state_t state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    coord_t line_cnt_q, line_cnt_d;
    coord_t frame_cnt_q, frame_cnt_d;
    coord_t line_len_q, line_len_d;
    coord_t frame_lines_q, frame_lines_d;
    logic   reload_q, reload_d;
    logic   line_seen_q, line_seen_d;
    logic   frame_seen_q, frame_seen_d;
    logic   frame_lerr_q, frame_lerr_d;
    logic   active_q, active_d;
    logic   locked_q, locked_d;
    logic   new_frame_q, new_frame_d;
    logic   line_err_q, line_err_d;
    logic   frame_err_q, frame_err_d;
    logic   blank_err_q, blank_err_d;

    logic   line_bad;
    logic   frame_bad;
    logic   pix_vis;
    logic   frame_good;

    vga_fall_det u_hs_det (
        .clk  (Clk),
        .rst  (Reset),
        .en   (pix_en),
        .d_in (hs_in),
        .fall (hs_fall)
    );

    vga_fall_det u_vs_det (
        .clk  (Clk),
        .rst  (Reset),
        .en   (pix_en),
        .d_in (vs_in),
        .fall (vs_fall)
    );

    // A vs edge on the same sample as the hs edge reloads immediately rather than waiting a line
    assign do_reload = hs_fall & (reload_q | vs_fall);

    // Coordinate recovery, line/frame measurement and error detection for the current sample
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        reload_d      = reload_q;
        line_seen_d   = line_seen_q;
        frame_seen_d  = frame_seen_q;
        frame_lerr_d  = frame_lerr_q;
        new_frame_d   = 1'b0;
        line_bad      = 1'b0;
        frame_bad     = 1'b0;
        pix_vis       = 1'b0;
        frame_good    = 1'b0;

        if (pix_en) begin
            if (hs_fall) begin
                x_d = HSS;
            end else if (x_q == HT_LAST) begin
                x_d = '0;
            end else begin
                x_d = x_q + 10'd1;
            end

            line_cnt_d = sat_inc(line_cnt_q);
            if (vs_fall) begin
                reload_d = 1'b1;
            end

            if (hs_fall) begin
                line_len_d  = line_cnt_q;
                line_cnt_d  = 10'd1;
                line_seen_d = 1'b1;
                line_bad    = line_seen_q && (line_cnt_q != HT);

                if (do_reload) begin
                    y_d           = VSS;
                    reload_d      = 1'b0;
                    new_frame_d   = 1'b1;
                    frame_lines_d = frame_cnt_q;
                    frame_cnt_d   = 10'd1;
                    frame_seen_d  = 1'b1;
                    frame_bad     = frame_seen_q && (frame_cnt_q != VT);
                end else begin
                    y_d         = (y_q == VT_LAST) ? '0 : y_q + 10'd1;
                    frame_cnt_d = sat_inc(frame_cnt_q);
                end
            end

            pix_vis = (x_d < HA) && (y_d < VA);
        end

        line_err_d  = line_bad && (state_q != SEARCH);
        frame_err_d = frame_bad && (state_q != SEARCH);
        blank_err_d = pix_en && (blank_in != pix_vis) && (state_q == LOCKED);

        // A frame is spoiled by any bad line, including the one closing at the reload edge
        frame_good = (frame_cnt_q == VT) && !frame_lerr_q && !line_err_d;
        if (do_reload) begin
            frame_lerr_d = 1'b0;
        end else if (line_err_d) begin
            frame_lerr_d = 1'b1;
        end
    end

    // Lock FSM next state; advances only on reload edges or on errors while locked
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;

        case (state_q)
            SEARCH: begin
                if (do_reload) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ACQUIRE: begin
                if (do_reload) begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_err_d || frame_err_d || blank_err_d) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
        active_d = (x_d < HA) && (y_d < VA) && locked_d;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q           <= '0;
            y_q           <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            reload_q      <= 1'b0;
            line_seen_q   <= 1'b0;
            frame_seen_q  <= 1'b0;
            frame_lerr_q  <= 1'b0;
            active_q      <= 1'b0;
            locked_q      <= 1'b0;
            new_frame_q   <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            blank_err_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            reload_q      <= reload_d;
            line_seen_q   <= line_seen_d;
            frame_seen_q  <= frame_seen_d;
            frame_lerr_q  <= frame_lerr_d;
            active_q      <= active_d;
            locked_q      <= locked_d;
            new_frame_q   <= new_frame_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            blank_err_q   <= blank_err_d;
        end
    end

    assign RecX        = x_q;
    assign RecY        = y_q;
    assign active      = active_q;
    assign locked      = locked_q;
    assign new_frame   = new_frame_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign blank_err   = blank_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Directed bench for vga_sync_tracker on a reduced 20x12 raster so whole frames stay short.
// Latency: outputs are read on the falling edge right after the sampling rising edge.
// Backpressure: none; pix_en is driven high every other Clk.
module tb_vga_sync_tracker;

    localparam int HT    = 20;
    localparam int VT    = 12;
    localparam int HA    = 12;
    localparam int VA    = 8;
    localparam int HSS   = 14;
    localparam int VSS   = 9;
    localparam int HSW   = 3;
    localparam int VSW   = 2;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       hs_in;
    logic       vs_in;
    logic       blank_in;
    logic [9:0] rec_x;
    logic [9:0] rec_y;
    logic       active;
    logic       locked;
    logic       new_frame;
    logic       line_err;
    logic       frame_err;
    logic       blank_err;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    always #5 clk = ~clk;

    vga_sync_tracker #(
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA),
        .H_SYNC_START (HSS),
        .V_SYNC_START (VSS),
        .LOCK_FRAMES  (2)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .pix_en      (pix_en),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .blank_in    (blank_in),
        .RecX        (rec_x),
        .RecY        (rec_y),
        .active      (active),
        .locked      (locked),
        .new_frame   (new_frame),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .blank_err   (blank_err),
        .line_len    (line_len),
        .frame_lines (frame_lines)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ex, ey, sent_x, sent_y;
    int nf_seen, le_seen, fe_seen, be_seen;
    bit skip_line = 1'b0;

    // Source raster: lines advance at the hs edge, so vs and hs fall on the same sample
    function automatic logic [2:0] sigs(input int x, input int y);
        logic h, v, b;
        h = !(x >= HSS && x < HSS + HSW);
        v = !(y >= VSS && y < VSS + VSW);
        b = (x < HA) && (y < VA);
        return {h, v, b};
    endfunction

    task automatic clear_seen();
        nf_seen = 0; le_seen = 0; fe_seen = 0; be_seen = 0;
    endtask

    task automatic pix(input logic h, input logic v, input logic b);
        @(negedge clk);
        pix_en = 1'b1; hs_in = h; vs_in = v; blank_in = b;
        @(negedge clk);
        pix_en = 1'b0;
        nf_seen += int'(new_frame);
        le_seen += int'(line_err);
        fe_seen += int'(frame_err);
        be_seen += int'(blank_err);
    endtask

    task automatic advance();
        ex = (ex == HT - 1) ? 0 : ex + 1;
        if (ex == HSS) begin
            ey = (ey == VT - 1) ? 0 : ey + 1;
            if (skip_line && ey == VA) begin
                ey = VSS;
                skip_line = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [2:0] s;
        s = sigs(ex, ey);
        sent_x = ex;
        sent_y = ey;
        pix(s[2], s[1], s[0]);
        advance();
    endtask

    task automatic walk_to(input int x, input int y);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (ex == x && ey == y) break;
            step();
        end
    endtask

    task automatic run_to_lock(input int budget, output int nf, output bit ok);
        int n0;
        n0 = nf_seen;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (locked) begin
                ok = 1'b1;
                break;
            end
        end
        nf = nf_seen - n0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (rec_x !== 10'd0 || rec_y !== 10'd0)
            $display("FAIL reset_coord: got x=%0d y=%0d want 0 0", rec_x, rec_y);
        else n_pass++;
        n_chk++;
        if ({active, locked, new_frame, line_err, frame_err, blank_err} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000",
                     {active, locked, new_frame, line_err, frame_err, blank_err});
        else n_pass++;
        n_chk++;
        if (line_len !== 10'd0 || frame_lines !== 10'd0)
            $display("FAIL reset_meas: got line_len=%0d frame_lines=%0d want 0 0", line_len, frame_lines);
        else n_pass++;
    endtask

    task automatic test_line_saturate();
        clear_seen();
        for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1, 1'b0);
        pix(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (line_len !== 10'd1023 || rec_x !== 10'(HSS))
            $display("FAIL line_saturate: got line_len=%0d x=%0d want 1023 %0d", line_len, rec_x, HSS);
        else n_pass++;
        n_chk++;
        if (le_seen + fe_seen + be_seen != 0 || locked !== 1'b0)
            $display("FAIL search_quiet: got errs=%0d locked=%b want 0 0",
                     le_seen + fe_seen + be_seen, locked);
        else n_pass++;
    endtask

    task automatic test_ideal();
        bit first, found;
        int bad, nf0;
        do_reset();
        ex = 0; ey = 0;
        clear_seen();
        first = 1'b1;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (locked) break;
            step();
            if (new_frame && first) begin
                first = 1'b0;
                n_chk++;
                if (rec_y !== 10'(VSS) || rec_x !== 10'(HSS))
                    $display("FAIL first_reload: got x=%0d y=%0d want %0d %0d", rec_x, rec_y, HSS, VSS);
                else n_pass++;
            end
        end
        n_chk++;
        if (locked !== 1'b1 || new_frame !== 1'b1 || nf_seen != 3)
            $display("FAIL lock_rise: got locked=%b new_frame=%b reloads=%0d want 1 1 3",
                     locked, new_frame, nf_seen);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (new_frame !== 1'b0 || locked !== 1'b1)
            $display("FAIL pulse_width: got new_frame=%b locked=%b want 0 1", new_frame, locked);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (sent_x == 0 && sent_y == 0) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found || rec_x !== 10'd0 || rec_y !== 10'd0 || active !== 1'b1)
            $display("FAIL first_visible: got found=%b x=%0d y=%0d active=%b want 1 0 0 1",
                     found, rec_x, rec_y, active);
        else n_pass++;
        bad = 0;
        nf0 = nf_seen;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (rec_x !== 10'(sent_x) || rec_y !== 10'(sent_y) ||
                active !== ((sent_x < HA) && (sent_y < VA)) || locked !== 1'b1)
                bad++;
        end
        n_chk++;
        if (bad != 0)
            $display("FAIL coord_track: got %0d mismatching pixels want 0", bad);
        else n_pass++;
        n_chk++;
        if (nf_seen - nf0 != 1 || frame_lines !== 10'(VT) || line_len !== 10'(HT))
            $display("FAIL frame_meas: got reloads=%0d frame_lines=%0d line_len=%0d want 1 %0d %0d",
                     nf_seen - nf0, frame_lines, line_len, VT, HT);
        else n_pass++;
        n_chk++;
        if (le_seen + fe_seen + be_seen != 0)
            $display("FAIL ideal_errs: got %0d error pulses want 0", le_seen + fe_seen + be_seen);
        else n_pass++;
    endtask

    task automatic test_line_stretch();
        logic [2:0] s;
        int nf;
        bit ok;
        walk_to(HT - 1, VSS);
        step();
        s = sigs(HT - 1, VSS);
        pix(s[2], s[1], s[0]);
        clear_seen();
        for (int i = 0; i < 3 * HT; i++) begin
            step();
            if (le_seen != 0) break;
        end
        n_chk++;
        if (le_seen != 1 || line_err !== 1'b1 || line_len !== 10'(HT + 1) || sent_x != HSS)
            $display("FAIL stretch_err: got pulses=%0d line_len=%0d at x=%0d want 1 %0d %0d",
                     le_seen, line_len, sent_x, HT + 1, HSS);
        else n_pass++;
        n_chk++;
        if (locked !== 1'b0 || be_seen != 0)
            $display("FAIL stretch_unlock: got locked=%b blank_errs=%0d want 0 0", locked, be_seen);
        else n_pass++;
        clear_seen();
        run_to_lock(6 * FRAME, nf, ok);
        n_chk++;
        if (!ok || nf != 3)
            $display("FAIL stretch_relock: got locked=%b reloads=%0d want 1 3", ok, nf);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        int nf;
        bit ok;
        skip_line = 1'b1;
        clear_seen();
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (fe_seen != 0) break;
        end
        n_chk++;
        if (fe_seen != 1 || frame_err !== 1'b1 || frame_lines !== 10'(VT - 1) || new_frame !== 1'b1)
            $display("FAIL short_frame: got pulses=%0d frame_lines=%0d new_frame=%b want 1 %0d 1",
                     fe_seen, frame_lines, new_frame, VT - 1);
        else n_pass++;
        n_chk++;
        if (locked !== 1'b0 || le_seen != 0 || be_seen != 0)
            $display("FAIL short_unlock: got locked=%b line_errs=%0d blank_errs=%0d want 0 0 0",
                     locked, le_seen, be_seen);
        else n_pass++;
        clear_seen();
        run_to_lock(6 * FRAME, nf, ok);
        n_chk++;
        if (!ok || nf != 3)
            $display("FAIL short_relock: got locked=%b reloads=%0d want 1 3", ok, nf);
        else n_pass++;
    endtask

    task automatic test_blank();
        logic [2:0] s;
        int nf;
        bit ok;
        walk_to(5, 3);
        s = sigs(5, 3);
        sent_x = 5;
        sent_y = 3;
        clear_seen();
        pix(s[2], s[1], 1'b0);
        advance();
        n_chk++;
        if (blank_err !== 1'b1 || locked !== 1'b0 || rec_x !== 10'd5 || rec_y !== 10'd3)
            $display("FAIL blank_err: got blank_err=%b locked=%b x=%0d y=%0d want 1 0 5 3",
                     blank_err, locked, rec_x, rec_y);
        else n_pass++;
        run_to_lock(6 * FRAME, nf, ok);
        n_chk++;
        if (be_seen != 1)
            $display("FAIL blank_once: got %0d blank_err pulses want 1", be_seen);
        else n_pass++;
        n_chk++;
        if (!ok || nf != 3)
            $display("FAIL blank_relock: got locked=%b reloads=%0d want 1 3", ok, nf);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int bad, nf;
        bit ok, found;
        walk_to(5, 3);
        do_reset();
        n_chk++;
        if (rec_x !== 10'd0 || rec_y !== 10'd0 || line_len !== 10'd0 || frame_lines !== 10'd0)
            $display("FAIL midreset_vals: got x=%0d y=%0d line_len=%0d frame_lines=%0d want 0 0 0 0",
                     rec_x, rec_y, line_len, frame_lines);
        else n_pass++;
        n_chk++;
        if ({active, locked, new_frame, line_err, frame_err, blank_err} !== 6'b0)
            $display("FAIL midreset_flags: got %b want 000000",
                     {active, locked, new_frame, line_err, frame_err, blank_err});
        else n_pass++;
        clear_seen();
        bad = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (new_frame) begin
                found = 1'b1;
                break;
            end
            if (locked || active || line_err || frame_err || blank_err) bad++;
        end
        n_chk++;
        if (!found || bad != 0 || locked !== 1'b0)
            $display("FAIL midreset_hold: got reload=%b stray=%0d locked=%b want 1 0 0", found, bad, locked);
        else n_pass++;
        run_to_lock(4 * FRAME, nf, ok);
        n_chk++;
        if (!ok || nf != 2)
            $display("FAIL midreset_relock: got locked=%b reloads=%0d want 1 2", ok, nf);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
        ex = 0; ey = 0; sent_x = 0; sent_y = 0;
        clear_seen();
        test_reset();
        test_line_saturate();
        test_ideal();
        test_line_stretch();
        test_short_frame();
        test_blank();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_tracker.md
# vga_sync_tracker

Sink-side companion to the 640x480 VGA timing generator. It consumes a pixel-rate strobe plus hs/vs/blank, recovers the pixel coordinate, and measures line and frame lengths. A lock FSM declares the stream valid only after consecutive well-formed frames. It feeds frame-capture and self-check logic that sits downstream of a video source.

## Interface
Parameters:
- H_TOTAL, 800: pixels per line.
- V_TOTAL, 525: lines per frame.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- H_SYNC_START, 656: X of the first hs-low pixel.
- V_SYNC_START, 490: Y of the first line after the vs falling edge.
- LOCK_FRAMES, 2: consecutive good frames needed to lock (1..15).

Ports:
- Clk, in, 1: system clock. One clock; reset is synchronous and active-high.
- Reset, in, 1: synchronous, active-high.
- pix_en, in, 1: one-Clk strobe per pixel; hs_in, vs_in and blank_in are sampled only on it.
- hs_in, in, 1: horizontal sync, active low.
- vs_in, in, 1: vertical sync, active low.
- blank_in, in, 1: display-enable; 1 = visible pixel.
- RecX, out, 10: recovered pixel X.
- RecY, out, 10: recovered line Y.
- active, out, 1: RecX < H_ACTIVE && RecY < V_ACTIVE && locked.
- locked, out, 1: lock status.
- new_frame, out, 1: one-Clk pulse when RecY reloads.
- line_err, out, 1: one-Clk pulse when a completed line length ≠ H_TOTAL.
- frame_err, out, 1: one-Clk pulse when a completed frame's line count ≠ V_TOTAL.
- blank_err, out, 1: one-Clk pulse when blank_in disagrees with the recovered active region while locked.
- line_len, out, 10: last completed line length in pixels, saturating at 1023.
- frame_lines, out, 10: last completed frame length in lines, saturating at 1023.

## Operation
- Edge detection uses the previous pix_en sample. hs_q and vs_q reset to 1. A falling edge is prev=1, cur=0 at a pix_en sample.
- **Pixel counter.**
  - On an hs falling edge, X := H_SYNC_START.
  - Otherwise, on pix_en, X increments and wraps from H_TOTAL-1 to 0.
- **Line measurement.** A pixel counter runs since the last hs edge. On each hs edge:
  - line_len := count; the count restarts at 1.
  - If the line was fully observed (a previous edge was seen since SEARCH exit) and count ≠ H_TOTAL, pulse line_err.
- **Line counter.**
  - Each hs edge increments Y, wrapping V_TOTAL-1 → 0.
  - A vs falling edge arms `reload`. At the next hs edge, Y := V_SYNC_START instead of incrementing, new_frame pulses and `reload` clears.
  - If vs and hs fall on the same sample, the reload applies at that edge.
- **Frame measurement.** A line counter counts hs edges since the last reload. At each reload:
  - frame_lines := count.
  - If a full frame was observed and count ≠ V_TOTAL, pulse frame_err.
- **FSM** (states SEARCH, ACQUIRE, LOCKED):
  - SEARCH: wait for the first reload → ACQUIRE, good_cnt := 0. Error pulses are suppressed.
  - ACQUIRE: at each reload, a frame is good if frame_lines == V_TOTAL and no line_err occurred during it.
    - Good frame: good_cnt++. When good_cnt reaches LOCK_FRAMES → LOCKED.
    - Bad frame: good_cnt := 0 and stay in ACQUIRE.
  - LOCKED: any line_err, frame_err or blank_err → SEARCH and locked drops. A reload with no error stays in LOCKED.
- **Blank check.** Active only in LOCKED. On each pix_en sample, compare blank_in with (X < H_ACTIVE && Y < V_ACTIVE) for the pixel being sampled.
- All counters are 10 bits. Measurement counters saturate at 1023 rather than wrap.

## Timing
- All outputs are registered. Coordinates and flags reflect a pix_en sample on the Clk edge after that sample (latency 1 Clk).
- Error and new_frame pulses last exactly one Clk, even if pix_en is held high continuously.
- locked rises in the same cycle as the new_frame that completes the LOCK_FRAMES-th good frame. It falls in the cycle the causing error pulse is asserted.
- With pix_en low, outputs other than the 1-cycle pulses hold their values.
- Reset values: RecX=0, RecY=0, active=0, locked=0, new_frame=0, line_err=0, frame_err=0, blank_err=0, line_len=0, frame_lines=0. Internal state: FSM=SEARCH, hs_q=vs_q=1, reload=0, good_cnt=0.
- Reset mid-frame fully restarts acquisition; no partial measurement survives.

## Structure
- Shared package `vga_pkg` holds:
  - The default timing constants (800/525/640/480/656/490).
  - The typedef `sync_state_t` {SEARCH, ACQUIRE, LOCKED}.
  - The 10-bit coordinate typedef `coord_t`.
- Sub-module `vga_fall_det` (registered falling-edge detector with enable and reset-to-1). It is instantiated twice, for hs and vs.

## Test plan
- Reset, then an ideal 800x525 stream with pix_en every other Clk:
  - new_frame at the first reload.
  - locked=1 at the end of the 2nd complete frame.
  - At the first visible pixel: RecX=0, RecY=0, active=1.
  - No error pulses.
- Locked stream, then one line stretched to 801 pixels:
  - line_err pulses with line_len=801.
  - locked falls the same cycle.
  - Relock takes 1 reload plus 2 good frames.
- Locked stream, then a frame of 524 lines: frame_err pulses, frame_lines=524, FSM goes to SEARCH.
- Locked stream, then blank_in forced to 0 at X=100, Y=50: blank_err pulses once and locked drops.
- vs and hs falling on the same pix_en sample: RecY=490 after that edge with no extra increment; new_frame pulses once.
- Reset asserted mid-line while locked, then released:
  - All outputs hold reset values until the first reload.
  - locked returns after 2 further good frames.
